mpu_cfg_seq: RTL and testbench



---
 rtl/mpu_cfg_seq.sv | 136 +++++++++++++
 tb/tb_mpu_cfg_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_cfg_seq.sv
`default_nettype none
// ============================================================================
// mpu_cfg_seq : MPU1 boot/re-config write sequencer (unlock, baud, rate,
//               content, save) with settle gap, timeout and bounded retry.
// Revision    : 1.0
// ============================================================================
module mpu_cfg_seq #(
   parameter int unsigned GAP_CYCLES     = 50000,
   parameter int unsigned TIMEOUT_CYCLES = 5000000,
   parameter int unsigned MAX_RETRY      = 2,
   parameter logic [15:0] BAUD_CODE      = 16'h0006,
   parameter logic [15:0] RATE_CODE      = 16'h0006,
   parameter logic [15:0] RSW_CODE       = 16'h0006
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_value,
   output logic        cfg_req,
   input  logic        cfg_done,
   output logic        busy,
   output logic        seq_done,
   output logic        seq_err,
   output logic [2:0]  err_idx
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

   localparam int          RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
   localparam logic [2:0]  LAST_IDX     = 3'd4;
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   // The ISSUE cycle is itself the last idle cycle before the registered
   // cfg_req, so GAP only has to cover GAP_CYCLES-1 cycles.
   localparam logic [31:0] GAP_LAST     = (GAP_CYCLES > 1) ? 32'(GAP_CYCLES - 2) : 32'd0;
   localparam state_t      GAP_NEXT     = (GAP_CYCLES > 1) ? S_GAP : S_ISSUE;

   state_t               r_state;
   logic [2:0]           r_idx;
   logic [31:0]          r_timer;
   logic [RETRY_W-1:0]   r_retry;
   logic [7:0]           w_addr;
   logic [15:0]          w_value;

   always_comb begin
      w_addr  = 8'h00;
      w_value = 16'h0000;
      case (r_idx)
         3'd0: begin w_addr = 8'h69; w_value = 16'hB588;  end
         3'd1: begin w_addr = 8'h04; w_value = BAUD_CODE; end
         3'd2: begin w_addr = 8'h03; w_value = RATE_CODE; end
         3'd3: begin w_addr = 8'h02; w_value = RSW_CODE;  end
         default: begin w_addr = 8'h00; w_value = 16'h0000; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_timer   <= '0;
         r_retry   <= '0;
         cfg_addr  <= '0;
         cfg_value <= '0;
         cfg_req   <= 1'b0;
         busy      <= 1'b0;
         seq_done  <= 1'b0;
         seq_err   <= 1'b0;
         err_idx   <= '0;
      end else begin
         cfg_req  <= 1'b0;
         seq_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  seq_err <= 1'b0;
                  err_idx <= '0;
                  r_idx   <= '0;
                  r_retry <= '0;
                  busy    <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cfg_req   <= 1'b1;
               cfg_addr  <= w_addr;
               cfg_value <= w_value;
               r_timer   <= '0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // An acknowledge on the expiry cycle still counts as success.
               if (cfg_done) begin
                  if (r_idx == LAST_IDX) begin
                     seq_done <= 1'b1;
                     busy     <= 1'b0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_retry <= '0;
                     r_timer <= '0;
                     r_state <= GAP_NEXT;
                  end
               end else if (r_timer == TIMEOUT_LAST) begin
                  if (r_retry != RETRY_LIMIT) begin
                     r_retry <= r_retry + RETRY_W'(1);
                     r_timer <= '0;
                     r_state <= GAP_NEXT;
                  end else begin
                     seq_err <= 1'b1;
                     err_idx <= r_idx;
                     busy    <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
            S_GAP: begin
               if (r_timer == GAP_LAST) begin
                  r_state <= S_ISSUE;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mpu_cfg_seq.sv
`default_nettype none
// ============================================================================
// tb_mpu_cfg_seq : scoreboard bench for mpu_cfg_seq (GAP=4, TIMEOUT=20, RETRY=1)
// Revision       : 1.0
// ============================================================================
module tb_mpu_cfg_seq;

   localparam int GAP = 4;
   localparam int TMO = 20;
   localparam int MR  = 1;

   localparam int K_REQ  = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   localparam int A_ACK   = 0;  // ack 3 cycles after request
   localparam int A_RACE  = 1;  // ack on the timer expiry cycle
   localparam int A_RETRY = 2;  // no ack, a retry is still available
   localparam int A_FAIL  = 3;  // no ack, retries exhausted
   localparam int A_NOISE = 4;  // ack plus stray start in WAIT and stray done in GAP
   localparam int A_RST   = 5;  // ack, then reset pulse inside the following gap

   typedef struct {
      int kind;
      int idx;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cfg_done = 1'b0;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_value;
   logic        cfg_req;
   logic        busy;
   logic        seq_done;
   logic        seq_err;
   logic [2:0]  err_idx;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   logic err_q = 1'b0;

   logic [7:0]  exp_addr  [5] = '{8'h69, 8'h04, 8'h03, 8'h02, 8'h00};
   logic [15:0] exp_value [5] = '{16'hB588, 16'h0006, 16'h0006, 16'h0006, 16'h0000};

   mpu_cfg_seq #(
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (MR),
      .BAUD_CODE      (16'h0006),
      .RATE_CODE      (16'h0006),
      .RSW_CODE       (16'h0006)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_addr  (cfg_addr),
      .cfg_value (cfg_value),
      .cfg_req   (cfg_req),
      .cfg_done  (cfg_done),
      .busy      (busy),
      .seq_done  (seq_done),
      .seq_err   (seq_err),
      .err_idx   (err_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int idx, input int c);
      exp_t e;
      e.kind = kind;
      e.idx  = idx;
      e.cyc  = c;
      q.push_back(e);
   endtask

   // Monitor: pops one expectation per observed DUT output event.
   task automatic observe(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d addr 0x%0h at cycle %0d, expected none",
                  kind, cfg_addr, cyc);
         return;
      end
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == K_REQ) begin
         chk("req_addr", cfg_addr, exp_addr[e.idx]);
         chk("req_value", cfg_value, exp_value[e.idx]);
         chk("req_busy", busy, 1);
         chk("req_seq_err", seq_err, 0);
      end else if (kind == K_DONE) begin
         chk("done_busy", busy, 0);
         chk("done_seq_err", seq_err, 0);
      end else begin
         chk("err_idx", err_idx, e.idx);
         chk("err_busy", busy, 0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (cfg_req)            observe(K_REQ);
         if (seq_done)           observe(K_DONE);
         if (seq_err && !err_q)  observe(K_ERR);
      end
      err_q = seq_err;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_seq();
      step();
      start = 1'b1;
      push(K_REQ, 0, cyc + 2);
      step();
      start = 1'b0;
   endtask

   task automatic wait_req(output int r);
      int n;
      n = 0;
      @(negedge clk);
      while (!cfg_req && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_req) begin
         n_cmp++;
         n_bad++;
         $display("FAIL req_timeout: got no cfg_req within 200 cycles, expected one");
      end
      r = cyc;
   endtask

   task automatic ack_at(input int t);
      do step(); while (cyc < t);
      cfg_done = 1'b1;
      step();
      cfg_done = 1'b0;
   endtask

   task automatic do_req(input int idx, input int act);
      int r;
      int d;
      wait_req(r);
      if (act == A_RACE || act == A_RETRY || act == A_FAIL) d = r + TMO - 1;
      else                                                    d = r + 3;
      if (act == A_RETRY)     push(K_REQ, idx, d + GAP + 1);
      else if (act == A_FAIL) push(K_ERR, idx, d + 1);
      else if (act != A_RST) begin
         if (idx < 4) push(K_REQ, idx + 1, d + GAP + 1);
         else         push(K_DONE, 0, d + 1);
      end
      if (act == A_NOISE) begin
         step();
         start = 1'b1;
         step();
         start = 1'b0;
      end
      if (act != A_RETRY && act != A_FAIL) ack_at(d);
      if (act == A_NOISE) begin
         step();
         cfg_done = 1'b1;
         step();
         cfg_done = 1'b0;
      end
      if (act == A_RST) begin
         step();
         rst = 1'b1;
         step();
         rst = 1'b0;
         @(negedge clk);
         chk("rst_outputs_zero",
             {cfg_addr, cfg_value, cfg_req, busy, seq_done, seq_err, err_idx}, 0);
      end
   endtask

   task automatic drain(input string name, input int n);
      idle(n);
      chk(name, q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs_zero",
          {cfg_addr, cfg_value, cfg_req, busy, seq_done, seq_err, err_idx}, 0);

      // Nominal run
      start_seq();
      for (int i = 0; i < 5; i++) do_req(i, A_ACK);
      drain("nominal_pending", 6);

      // Single timeout on entry 2
      start_seq();
      do_req(0, A_ACK);
      do_req(1, A_ACK);
      do_req(2, A_RETRY);
      do_req(2, A_ACK);
      do_req(3, A_ACK);
      do_req(4, A_ACK);
      drain("timeout_pending", 6);

      // Entry 1 never acknowledged
      start_seq();
      do_req(0, A_ACK);
      do_req(1, A_RETRY);
      do_req(1, A_FAIL);
      drain("exhaust_pending", 40);
      chk("err_sticky", seq_err, 1);
      chk("err_idx_hold", err_idx, 1);
      chk("err_busy_low", busy, 0);

      // Restart after error, with ignored start/done noise
      start_seq();
      do_req(0, A_ACK);
      do_req(1, A_NOISE);
      do_req(2, A_ACK);
      do_req(3, A_ACK);
      do_req(4, A_ACK);
      drain("noise_pending", 6);
      chk("noise_err_clear", seq_err, 0);

      // Ack on the exact timeout cycle
      start_seq();
      do_req(0, A_ACK);
      do_req(1, A_RACE);
      do_req(2, A_ACK);
      do_req(3, A_ACK);
      do_req(4, A_RACE);
      drain("race_pending", 6);

      // Reset in the gap after entry 2, then a fresh run
      start_seq();
      do_req(0, A_ACK);
      do_req(1, A_ACK);
      do_req(2, A_RST);
      drain("rst_quiet", 40);
      start_seq();
      for (int i = 0; i < 5; i++) do_req(i, A_ACK);
      drain("rst_restart_pending", 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
